// File: rtl/accum_alu.sv
// accum_alu: registered, handshaked add/subtract unit with NCH independent
// accumulator channels and a single output register (one result per accepted
// command, full throughput).
// Optional feature: define ACCUM_ALU_SATURATE_EN to make ADD/ACC saturate to
// all-ones on carry-out and SUB saturate to zero on borrow. The default build
// uses wrap-around arithmetic.
module accum_alu #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int CHW   = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [CHW-1:0]   ch,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [CHW-1:0]   out_ch
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

`ifdef ACCUM_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [WIDTH-1:0] acc [NCH];

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH-1:0] acc_sel;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic [CHW-1:0]   nxt_ch;
  logic             acc_we;
  logic [WIDTH-1:0] acc_wdata;

  // The output register frees up when it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_sel  = acc[ch];

  // Datapath: all three arithmetic results are WIDTH+1 wide so the top bit is
  // the carry (ADD/ACC) or the borrow (SUB, set exactly when a < b).
  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign acc_sum  = {1'b0, acc_sel} + {1'b0, a};

  // Decode the command into the next output-register contents and the
  // accumulator write for the selected channel.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_ch     = '0;
    acc_we     = 1'b0;
    acc_wdata  = '0;
    unique case (op_e'(op))
      OP_ADD: begin
        nxt_carry  = add_sum[WIDTH];
        nxt_result = (SAT && add_sum[WIDTH]) ? '1 : add_sum[WIDTH-1:0];
      end
      OP_SUB: begin
        nxt_carry  = sub_diff[WIDTH];
        nxt_result = (SAT && sub_diff[WIDTH]) ? '0 : sub_diff[WIDTH-1:0];
      end
      OP_ACC: begin
        nxt_carry  = acc_sum[WIDTH];
        nxt_result = (SAT && acc_sum[WIDTH]) ? '1 : acc_sum[WIDTH-1:0];
        nxt_ch     = ch;
        acc_we     = 1'b1;
        acc_wdata  = nxt_result;
      end
      OP_CLR: begin
        nxt_result = acc_sel;
        nxt_ch     = ch;
        acc_we     = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register: load on accept, drop valid on a drain without accept,
  // otherwise hold. Reset discards any in-flight result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= nxt_result;
      carry     <= nxt_carry;
      out_ch    <= nxt_ch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator bank: only the selected channel is written, and only on accept.
  always_ff @(posedge clk) begin
    // NOTE: the accumulators are architectural state with a defined reset
    // value, so the bank is cleared in reset like ordinary flops rather than
    // left as an unreset memory.
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
    end else if (accept && acc_we) begin
      acc[ch] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
// tb_accum_alu: directed self-checking bench for accum_alu (WIDTH=8, NCH=4).
// Expected values are hand-computed; saturated variants are selected when
// ACCUM_ALU_SATURATE_EN is defined.
module tb_accum_alu;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CHW   = 2;

`ifdef ACCUM_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ACC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [CHW-1:0]   ch;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CHW-1:0]   out_ch;

  int n_cmp = 0;
  int n_err = 0;

  accum_alu #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .ch        (ch),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly one edge, then drop in_valid.
  task automatic cmd(input logic [1:0] c_op, input logic [CHW-1:0] c_ch,
                     input logic [WIDTH-1:0] c_a, input logic [WIDTH-1:0] c_b);
    in_valid = 1'b1;
    op = c_op;
    ch = c_ch;
    a  = c_a;
    b  = c_b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [WIDTH-1:0] r,
                            input logic c, input logic [CHW-1:0] oc);
    check({tag, ".valid"}, 16'(out_valid), 16'(1'b1));
    check({tag, ".result"}, 16'(result), 16'(r));
    check({tag, ".carry"}, 16'(carry), 16'(c));
    check({tag, ".out_ch"}, 16'(out_ch), 16'(oc));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = ADD; ch = '0; a = '0; b = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst.out_valid", 16'(out_valid), 16'(1'b0));
    check("rst.result", 16'(result), 16'(8'h00));
    check("rst.carry", 16'(carry), 16'(1'b0));
    check("rst.out_ch", 16'(out_ch), 16'(2'd0));
    check("rst.in_ready", 16'(in_ready), 16'(1'b1));
    rst_n = 1'b1;
    tick();

    // Basic ADD, one-cycle latency, drained on the following edge.
    cmd(ADD, 2'd3, 8'h0F, 8'h01);
    expect_out("add0", 8'h10, 1'b0, 2'd0);
    tick();
    check("add0.drain", 16'(out_valid), 16'(1'b0));
    check("add0.hold", 16'(result), 16'(8'h10));

    // ADD/SUB boundaries, back-to-back with out_ready=1.
    cmd(ADD, 2'd0, 8'hFF, 8'h02);
    expect_out("add_ovf", SAT ? 8'hFF : 8'h01, 1'b1, 2'd0);
    cmd(SUB, 2'd0, 8'h03, 8'h05);
    expect_out("sub_brw", SAT ? 8'h00 : 8'hFE, 1'b1, 2'd0);
    cmd(SUB, 2'd0, 8'h05, 8'h03);
    expect_out("sub_pos", 8'h02, 1'b0, 2'd0);
    cmd(SUB, 2'd0, 8'h07, 8'h07);
    expect_out("sub_eq", 8'h00, 1'b0, 2'd0);

    // Load neighbouring channels, then four back-to-back ACCs on channel 2.
    cmd(ACC, 2'd1, 8'h11, 8'hAA);
    expect_out("acc1", 8'h11, 1'b0, 2'd1);
    cmd(ACC, 2'd3, 8'h33, 8'h55);
    expect_out("acc3", 8'h33, 1'b0, 2'd3);
    cmd(ACC, 2'd2, 8'h40, 8'h00);
    expect_out("acc2_a", 8'h40, 1'b0, 2'd2);
    cmd(ACC, 2'd2, 8'h40, 8'h00);
    expect_out("acc2_b", 8'h80, 1'b0, 2'd2);
    cmd(ACC, 2'd2, 8'h40, 8'h00);
    expect_out("acc2_c", 8'hC0, 1'b0, 2'd2);
    cmd(ACC, 2'd2, 8'h40, 8'h00);
    expect_out("acc2_d", SAT ? 8'hFF : 8'h00, 1'b1, 2'd2);
    cmd(CLR, 2'd2, 8'h77, 8'h00);
    expect_out("clr2", SAT ? 8'hFF : 8'h00, 1'b0, 2'd2);
    cmd(CLR, 2'd2, 8'h00, 8'h00);
    expect_out("clr2_again", 8'h00, 1'b0, 2'd2);
    cmd(ADD, 2'd2, 8'h01, 8'h01);
    expect_out("add_ch0", 8'h02, 1'b0, 2'd0);
    cmd(ACC, 2'd1, 8'h00, 8'h00);
    expect_out("acc1_keep", 8'h11, 1'b0, 2'd1);
    cmd(ACC, 2'd3, 8'h00, 8'h00);
    expect_out("acc3_keep", 8'h33, 1'b0, 2'd3);
    tick();
    check("idle.drain", 16'(out_valid), 16'(1'b0));

    // Backpressure: first result held, second command stalled until drain.
    out_ready = 1'b0;
    cmd(ADD, 2'd0, 8'h01, 8'h02);
    expect_out("bp_first", 8'h03, 1'b0, 2'd0);
    in_valid = 1'b1; op = ADD; ch = 2'd0; a = 8'h10; b = 8'h20;
    #1;
    check("bp.in_ready_lo", 16'(in_ready), 16'(1'b0));
    tick();
    tick();
    expect_out("bp_held", 8'h03, 1'b0, 2'd0);
    check("bp.in_ready_still_lo", 16'(in_ready), 16'(1'b0));
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_hi", 16'(in_ready), 16'(1'b1));
    tick();
    in_valid = 1'b0;
    expect_out("bp_second", 8'h30, 1'b0, 2'd0);
    tick();
    check("bp.no_dup", 16'(out_valid), 16'(1'b0));
    check("bp.last_hold", 16'(result), 16'(8'h30));

    // Mid-stream reset discards the in-flight result and clears accumulators.
    out_ready = 1'b0;
    cmd(ACC, 2'd1, 8'h10, 8'h00);
    expect_out("mr_acc", 8'h21, 1'b0, 2'd1);
    rst_n = 1'b0;
    in_valid = 1'b1; op = ACC; ch = 2'd1; a = 8'h05; b = 8'h00;
    tick();
    in_valid = 1'b0;
    check("mr.out_valid", 16'(out_valid), 16'(1'b0));
    check("mr.result", 16'(result), 16'(8'h00));
    check("mr.out_ch", 16'(out_ch), 16'(2'd0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    cmd(ACC, 2'd1, 8'h01, 8'h00);
    expect_out("mr_after", 8'h01, 1'b0, 2'd1);
    cmd(ACC, 2'd3, 8'h00, 8'h00);
    expect_out("mr_ch3_clr", 8'h00, 1'b0, 2'd3);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accum_alu.md
Name: accum_alu

Overview:
- Parametrised successor to the team's 8-bit combinational adder top.
- Registered, handshaked add/subtract unit with NCH independent accumulator channels, one result per accepted command.
- Sits behind the pin-mux in a Tiny Tapeout user top; a thin wrapper maps ui_in/uio_in onto a/b/op and uo_out onto result.

Parameters:
- WIDTH, 8, operand/accumulator/result width in bits (>=2).
- NCH, 4, number of accumulator channels; power of 2, >=2.
- CHW, $clog2(NCH), channel-select width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  command present.
- in_ready  output  1  command accepted when in_valid && in_ready.
- op  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- ch  input  CHW  accumulator channel for ACC/CLR; ignored for ADD/SUB.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for ACC/CLR.
- out_valid  output  1  result register holds an undelivered result.
- out_ready  input  1  consumer takes result when out_valid && out_ready.
- result  output  WIDTH  result data.
- carry  output  1  carry/borrow/overflow flag for result.
- out_ch  output  CHW  channel of the command that produced result (0 for ADD/SUB).

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, result=0, carry=0, out_ch=0, all acc[i]=0. Reset wins over any concurrent handshake; an in-flight result is discarded.
- in_ready = !out_valid || out_ready (combinational; single output register, full throughput).
- Accept (in_valid && in_ready): on that edge result/carry/out_ch load and out_valid=1. Latency 1 cycle, accept to out_valid.
- No accept but out_valid && out_ready: out_valid=0 on that edge; result/carry/out_ch hold their values.
- Simultaneous drain and accept: out_valid stays 1 and the new result replaces the old one. No bubble.
- While out_valid && !out_ready: result, carry and out_ch hold stable; in_ready=0.
- ADD: {carry,result} = a + b, computed WIDTH+1 wide; wraps mod 2^WIDTH.
- SUB: result = a - b mod 2^WIDTH; carry = 1 iff a < b (borrow).
- ACC: {carry,sum} = acc[ch] + a; acc[ch] <= sum and result = sum, both on the accept edge.
- CLR: result = acc[ch] (old value); acc[ch] <= 0; carry = 0.
- Back-to-back ACC/CLR to the same channel see the value updated by the previous accept. No hazard and no stall.
- Channels are fully independent; non-selected accumulators never change.
- in_valid=0: no state changes except the output drain.

Optional Feature:
- Macro ACCUM_ALU_SATURATE_EN.
- Defined: ADD and ACC saturate to 2^WIDTH-1 on carry-out, and the accumulator stores the saturated value. SUB saturates to 0 on borrow. carry still reports that saturation occurred.
- Undefined: wrap-around arithmetic as above.

Test Plan:
- Reset then ADD a=8'h0F b=8'h01, out_ready=1 -> next cycle out_valid=1, result=8'h10, carry=0, out_ch=0; following cycle out_valid=0.
- ADD a=8'hFF b=8'h02 -> result=8'h01, carry=1. With ACCUM_ALU_SATURATE_EN -> result=8'hFF, carry=1.
- SUB a=8'h03 b=8'h05 -> result=8'hFE, carry=1. With saturation -> result=8'h00, carry=1.
- Four back-to-back ACC on ch=2 with a=8'h40, out_ready=1 -> results 40, 80, C0, 00 (carry=1 on last), out_ch=2. Then CLR ch=2 -> result=00, and acc[1]/acc[3] unchanged.
- Backpressure: out_ready=0 with two commands pending -> first result held stable, in_ready=0, second not accepted. Raise out_ready -> both delivered in order, no loss or duplicate.
- Mid-stream reset: ACC ch=1 a=8'h10 accepted, rst_n low while out_valid=1 -> out_valid=0. Then ACC ch=1 a=8'h01 -> result=8'h01.
